// File: rtl/car_light_pkg.sv
// ---------------------------------------------------------------------------
// car_light_pkg
// Shared constants for the car tail-light mode controller.
//   MODE_*          : 2-bit mode encoding seen on car_light_ctrl.o_mode
//   DEF_DEB_CYCLES  : default debounce length (20 ms at 12 MHz)
//   DEF_TICK_DIV    : default clk cycles per 1 s tick at 12 MHz
//   DEF_AUTO_OFF_S  : default seconds before a turn signal self-cancels
// Helper functions:
//   cnt_width()     : counter width able to hold 0..n-1, never below 1 bit
//   is_turn()       : true for LEFT or RIGHT
// ---------------------------------------------------------------------------
package car_light_pkg;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_LEFT   = 2'd1;
  localparam logic [1:0] MODE_RIGHT  = 2'd2;
  localparam logic [1:0] MODE_HAZARD = 2'd3;

  localparam int unsigned DEF_DEB_CYCLES = 240000;
  localparam int unsigned DEF_TICK_DIV   = 12000000;
  localparam int unsigned DEF_AUTO_OFF_S = 10;

  // A 1-cycle or 1-state counter still needs one bit so the RTL stays legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_turn(input logic [1:0] m);
    return (m == MODE_LEFT) || (m == MODE_RIGHT);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises one raw key into the clk domain, debounces it and produces a
// single-cycle press event on each debounced rising edge.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   i_key_in  in  raw key, active-high, asynchronous to clk
//   o_level   out debounced key level (registered)
//   o_press   out one-cycle pulse, high in the cycle the level rises
// Latency from a raw edge to o_level / o_press is 2 + DEB_CYCLES cycles.
// ---------------------------------------------------------------------------
module key_debounce
  import car_light_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_in,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned     CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key_in;
      r_sync2 <= r_sync1;
    end
  end

  // The counter only advances while the synchronised key disagrees with the
  // debounced level, so any bounce back to the old level restarts the wait.
  // The press pulse is registered together with the level so both appear in
  // the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == DEB_LAST) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/car_light_ctrl.sv
// ---------------------------------------------------------------------------
// car_light_ctrl
// Mode controller for the tail-light display. Debounces the turn, hazard and
// brake keys, arbitrates press events through an IDLE/LEFT/RIGHT/HAZARD state
// machine and cancels a turn signal automatically after AUTO_OFF_S seconds.
// Ports:
//   clk           in  system clock, single domain
//   rst_n         in  asynchronous active-low reset
//   i_key_left    in  raw left-turn key, active-high
//   i_key_right   in  raw right-turn key, active-high
//   i_key_hazard  in  raw hazard key, active-high
//   i_key_brake   in  raw brake key, active-high level
//   o_en_l        out left enable (LEFT or HAZARD), registered
//   o_en_r        out right enable (RIGHT or HAZARD), registered
//   o_brake_on    out debounced brake level, registered
//   o_mode        out current mode, see car_light_pkg MODE_*
//   o_auto_off    out one-cycle pulse, registered, when a turn self-cancels
// ---------------------------------------------------------------------------
module car_light_ctrl
  import car_light_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned AUTO_OFF_S = DEF_AUTO_OFF_S
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key_left,
  input  logic       i_key_right,
  input  logic       i_key_hazard,
  input  logic       i_key_brake,
  output logic       o_en_l,
  output logic       o_en_r,
  output logic       o_brake_on,
  output logic [1:0] o_mode,
  output logic       o_auto_off
);

  localparam int unsigned   TW        = cnt_width(TICK_DIV);
  localparam int unsigned   SW        = cnt_width(AUTO_OFF_S + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(AUTO_OFF_S - 1);

  logic          w_left_level_unused;
  logic          w_right_level_unused;
  logic          w_hazard_level_unused;
  logic          w_brake_press_unused;
  logic          w_left_press;
  logic          w_right_press;
  logic          w_hazard_press;
  logic          w_brake_level;

  logic [1:0]    r_state;
  logic          r_en_l;
  logic          r_en_r;
  logic          r_auto_off;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_sec_cnt;

  logic [1:0]    w_state_next;
  logic          w_tick;
  logic          w_in_turn;
  logic          w_timeout;
  logic          w_haz_ev;
  logic          w_left_ev;
  logic          w_right_ev;
  logic          w_any_ev;
  logic          w_enter_turn;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_key_in (i_key_left),
    .o_level  (w_left_level_unused),
    .o_press  (w_left_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_key_in (i_key_right),
    .o_level  (w_right_level_unused),
    .o_press  (w_right_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hazard (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_key_in (i_key_hazard),
    .o_level  (w_hazard_level_unused),
    .o_press  (w_hazard_press)
  );

  // Brake is a held level, so its press event has no consumer.
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_brake (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_key_in (i_key_brake),
    .o_level  (w_brake_level),
    .o_press  (w_brake_press_unused)
  );

  // Left and right arriving together are ambiguous, so both are dropped;
  // hazard is handled ahead of either turn inside the state machine.
  assign w_haz_ev   = w_hazard_press;
  assign w_left_ev  = w_left_press  & ~w_right_press;
  assign w_right_ev = w_right_press & ~w_left_press;
  assign w_any_ev   = w_haz_ev | w_left_ev | w_right_ev;

  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_in_turn = is_turn(r_state);
  assign w_timeout = w_in_turn && w_tick && (r_sec_cnt == SEC_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MODE_IDLE: begin
        if (w_haz_ev)        w_state_next = MODE_HAZARD;
        else if (w_left_ev)  w_state_next = MODE_LEFT;
        else if (w_right_ev) w_state_next = MODE_RIGHT;
      end
      MODE_LEFT: begin
        if (w_haz_ev)        w_state_next = MODE_HAZARD;
        else if (w_left_ev)  w_state_next = MODE_IDLE;
        else if (w_right_ev) w_state_next = MODE_RIGHT;
        else if (w_timeout)  w_state_next = MODE_IDLE;
      end
      MODE_RIGHT: begin
        if (w_haz_ev)        w_state_next = MODE_HAZARD;
        else if (w_right_ev) w_state_next = MODE_IDLE;
        else if (w_left_ev)  w_state_next = MODE_LEFT;
        else if (w_timeout)  w_state_next = MODE_IDLE;
      end
      MODE_HAZARD: begin
        if (w_haz_ev)        w_state_next = MODE_IDLE;
      end
      default:               w_state_next = MODE_IDLE;
    endcase
  end

  // Switching between LEFT and RIGHT counts as a fresh entry, so the
  // auto-cancel timer always gets its full AUTO_OFF_S seconds.
  assign w_enter_turn = is_turn(w_state_next) && (w_state_next != r_state);

  // Mode and enables are registered from the next state; auto_off is only
  // raised when the timeout actually caused the exit, never when a press
  // event in the same cycle took precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MODE_IDLE;
      r_en_l     <= 1'b0;
      r_en_r     <= 1'b0;
      r_auto_off <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_en_l     <= (w_state_next == MODE_LEFT)  || (w_state_next == MODE_HAZARD);
      r_en_r     <= (w_state_next == MODE_RIGHT) || (w_state_next == MODE_HAZARD);
      r_auto_off <= w_timeout && !w_any_ev;
    end
  end

  // The tick counter free-runs but is pulled back to zero on turn entry so
  // the first second after entering LEFT/RIGHT is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_enter_turn || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Seconds only accumulate while a turn signal is active; the timeout fires
  // on the tick that would have made the count reach AUTO_OFF_S.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_cnt <= '0;
    end else if (w_enter_turn) begin
      r_sec_cnt <= '0;
    end else if (w_in_turn && w_tick) begin
      r_sec_cnt <= r_sec_cnt + 1'b1;
    end
  end

  assign o_en_l     = r_en_l;
  assign o_en_r     = r_en_r;
  assign o_brake_on = w_brake_level;
  assign o_mode     = r_state;
  assign o_auto_off = r_auto_off;

endmodule

// File: tb/tb_car_light_ctrl.sv
// ---------------------------------------------------------------------------
// tb_car_light_ctrl
// Directed bench for car_light_ctrl with DEB_CYCLES=4, TICK_DIV=10,
// AUTO_OFF_S=3. Inputs change and outputs are sampled on the falling edge.
// A raw key raised at a falling edge shows its debounced level 6 falling
// edges later and the resulting mode change 7 falling edges later; a turn
// entered at rising edge E auto-cancels at rising edge E+30.
// ---------------------------------------------------------------------------
module tb_car_light_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       keyLeft;
  logic       keyRight;
  logic       keyHazard;
  logic       keyBrake;
  logic       enL;
  logic       enR;
  logic       brakeOn;
  logic [1:0] mode;
  logic       autoOff;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  car_light_ctrl #(
    .DEB_CYCLES (4),
    .TICK_DIV   (10),
    .AUTO_OFF_S (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .i_key_left   (keyLeft),
    .i_key_right  (keyRight),
    .i_key_hazard (keyHazard),
    .i_key_brake  (keyBrake),
    .o_en_l       (enL),
    .o_en_r       (enR),
    .o_brake_on   (brakeOn),
    .o_mode       (mode),
    .o_auto_off   (autoOff)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [1:0] expMode, input logic expL, input logic expR);
    checkOutput({tag, "_mode"}, {6'd0, mode}, {6'd0, expMode});
    checkOutput({tag, "_en_l"}, {7'd0, enL},  {7'd0, expL});
    checkOutput({tag, "_en_r"}, {7'd0, enR},  {7'd0, expR});
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic h, input logic b);
    keyLeft   = l;
    keyRight  = r;
    keyHazard = h;
    keyBrake  = b;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic sawAutoOff;

    // Reset held with keys toggling.
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i[0], ~i[0], i[1], 1'b1);
      @(negedge clk);
    end
    checkState("in_reset", 2'd0, 1'b0, 1'b0);
    checkOutput("in_reset_brake", {7'd0, brakeOn}, 8'd0);
    checkOutput("in_reset_auto_off", {7'd0, autoOff}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    rstN = 1'b1;
    waitCycles(10);
    checkState("after_reset", 2'd0, 1'b0, 1'b0);
    checkOutput("after_reset_brake", {7'd0, brakeOn}, 8'd0);
    checkOutput("after_reset_auto_off", {7'd0, autoOff}, 8'd0);

    // 3-cycle glitch on the left key is rejected.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(10);
    checkState("glitch", 2'd0, 1'b0, 1'b0);

    // Clean left press: mode changes exactly 7 cycles after the raw edge.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(6);
    checkOutput("left_latency_early", {6'd0, mode}, 8'd0);
    waitCycles(1);
    checkState("left_on", 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Auto-cancel 30 cycles after entry.
    waitCycles(29);
    checkOutput("auto_off_early", {7'd0, autoOff}, 8'd0);
    checkOutput("auto_off_early_mode", {6'd0, mode}, 8'd1);
    waitCycles(1);
    checkOutput("auto_off_pulse", {7'd0, autoOff}, 8'd1);
    checkState("auto_off_exit", 2'd0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("auto_off_one_cycle", {7'd0, autoOff}, 8'd0);
    checkState("auto_off_after", 2'd0, 1'b0, 1'b0);

    // LEFT then RIGHT: the timeout restarts from the switch.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(7);
    checkOutput("left_again", {6'd0, mode}, 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(6);
    checkOutput("switch_early", {6'd0, mode}, 8'd1);
    waitCycles(1);
    checkState("switch_right", 2'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(23);
    checkOutput("no_stale_timeout", {7'd0, autoOff}, 8'd0);
    checkOutput("no_stale_timeout_mode", {6'd0, mode}, 8'd2);
    waitCycles(6);
    checkOutput("right_auto_off_early", {7'd0, autoOff}, 8'd0);
    waitCycles(1);
    checkOutput("right_auto_off", {7'd0, autoOff}, 8'd1);
    checkState("right_auto_off_exit", 2'd0, 1'b0, 1'b0);

    // Simultaneous left and right from IDLE are both ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitCycles(10);
    checkState("both_ignored", 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(8);

    // Hazard on, left ignored, no auto-cancel, hazard off.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(7);
    checkState("hazard_on", 2'd3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(8);
    sawAutoOff = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (autoOff !== 1'b0) sawAutoOff = 1'b1;
      if (i == 7) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("hazard_no_auto_off", {7'd0, sawAutoOff}, 8'd0);
    checkState("hazard_ignores_left", 2'd3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(7);
    checkState("hazard_off", 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(8);

    // Brake level follows the key after 6 cycles without touching the mode.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(5);
    checkOutput("brake_early", {7'd0, brakeOn}, 8'd0);
    waitCycles(1);
    checkOutput("brake_on", {7'd0, brakeOn}, 8'd1);
    checkState("brake_no_mode", 2'd0, 1'b0, 1'b0);

    // Hazard beats left in the same cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitCycles(7);
    checkState("hazard_beats_left", 2'd3, 1'b1, 1'b1);
    checkOutput("brake_held", {7'd0, brakeOn}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(7);
    checkOutput("hazard_off_again", {6'd0, mode}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(6);
    checkOutput("brake_release", {7'd0, brakeOn}, 8'd0);
    waitCycles(2);

    // Left press landing in the timeout cycle wins; no auto_off pulse.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(7);
    checkOutput("race_enter", {6'd0, mode}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(23);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(6);
    checkOutput("race_before", {6'd0, mode}, 8'd1);
    waitCycles(1);
    checkState("race_exit", 2'd0, 1'b0, 1'b0);
    checkOutput("race_no_auto_off", {7'd0, autoOff}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("race_no_auto_off_after", {7'd0, autoOff}, 8'd0);
    checkOutput("race_stays_idle", {6'd0, mode}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
